// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Classifies button activity, delivered as single-cycle edge pulses plus a
// periodic timebase tick, into short, long and double presses. Each
// classified press produces exactly one registered, one-clock event pulse.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   tick          in   periodic timebase pulse, one clk wide
//   press_redge   in   one-cycle pulse on button press
//   press_fedge   in   one-cycle pulse on button release
//   short_press   out  pulse: single short press completed
//   long_press    out  pulse: hold reached LONG_TICKS
//   double_press  out  pulse: second short press released
//   held          out  level: button considered down
//   busy          out  level: a press sequence is in progress
// -----------------------------------------------------------------------------
module button_event_decoder #(
    parameter int LONG_TICKS   = 8,
    parameter int DCLICK_TICKS = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic press_redge,
    input  logic press_fedge,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic held,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_CNT   = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] DCLICK_CNT = CNT_W'(DCLICK_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             held_q, held_d;
    logic             busy_q, busy_d;

    logic             redge;
    logic             fedge;
    logic             tick_v;
    logic [CNT_W-1:0] cnt_inc;

    // Coincident edges cancel; any edge present in a cycle masks the tick.
    assign redge   = press_redge & ~press_fedge;
    assign fedge   = press_fedge & ~press_redge;
    assign tick_v  = tick & ~press_redge & ~press_fedge;
    assign cnt_inc = sat_inc(cnt_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (redge) begin
                    state_d = PRESS1;
                end else if (tick_v) begin
                    cnt_d = cnt_inc;
                end
            end
            PRESS1: begin
                if (fedge) begin
                    state_d = WAIT2;
                end else if (tick_v) begin
                    if (cnt_inc == LONG_CNT) begin
                        long_d  = 1'b1;
                        state_d = LONG_HOLD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            WAIT2: begin
                if (redge) begin
                    state_d = PRESS2;
                end else if (tick_v) begin
                    // The window closed without a second press.
                    if (cnt_inc == DCLICK_CNT) begin
                        short_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            PRESS2: begin
                if (fedge) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end else if (tick_v) begin
                    // Second press held long: the first tap is dropped.
                    if (cnt_inc == LONG_CNT) begin
                        long_d  = 1'b1;
                        state_d = LONG_HOLD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            LONG_HOLD: begin
                if (fedge) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Levels are registered from the next state so they line up with it.
        held_d = (state_d == PRESS1) || (state_d == PRESS2) || (state_d == LONG_HOLD);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            held_q   <= held_d;
            busy_q   <= busy_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign held         = held_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;

    localparam int LONG_T   = 8;
    localparam int DCLICK_T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic press_redge = 1'b0;
    logic press_fedge = 1'b0;
    logic short_press, long_press, double_press, held, busy;

    int errors = 0;
    int checks = 0;
    int n_short = 0, n_long = 0, n_double = 0;

    // Event-level reference: button down?, in a long hold?, how many short
    // taps are pending, ticks counted since the last press/release.
    bit m_down, m_long;
    int m_taps, m_ticks;
    logic [4:0] m_out;

    typedef struct {
        bit r, f, t;
        logic [4:0] exp;   // {short, long, double, held, busy}
    } vec_t;
    vec_t tbl[13];

    button_event_decoder #(
        .LONG_TICKS(LONG_T), .DCLICK_TICKS(DCLICK_T), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .press_redge(press_redge), .press_fedge(press_fedge),
        .short_press(short_press), .long_press(long_press),
        .double_press(double_press), .held(held), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] dut_out();
        return {short_press, long_press, double_press, held, busy};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_down = 0; m_long = 0; m_taps = 0; m_ticks = 0; m_out = '0;
    endtask

    task automatic model_step(input bit r, input bit f, input bit t);
        bit re, fe, te, es, el, ed;
        re = r && !f; fe = f && !r; te = t && !r && !f;
        es = 0; el = 0; ed = 0;
        if (m_long) begin
            if (fe) begin m_long = 0; m_down = 0; end
        end else if (m_down) begin
            if (fe) begin
                m_down = 0; m_ticks = 0;
                if (m_taps == 1) begin ed = 1; m_taps = 0; end
                else m_taps = 1;
            end else if (te) begin
                m_ticks++;
                if (m_ticks == LONG_T) begin el = 1; m_long = 1; m_taps = 0; end
            end
        end else if (m_taps == 1) begin
            if (re) begin m_down = 1; m_ticks = 0; end
            else if (te) begin
                m_ticks++;
                if (m_ticks == DCLICK_T) begin es = 1; m_taps = 0; end
            end
        end else if (re) begin
            m_down = 1; m_ticks = 0;
        end
        m_out = {es, el, ed, m_down, (m_down || m_taps == 1)};
    endtask

    // Drive one cycle of inputs, clock it, sample 1 ns after the edge.
    task automatic apply(input bit r, input bit f, input bit t);
        press_redge = r; press_fedge = f; tick = t;
        @(posedge clk);
        #1;
        press_redge = 0; press_fedge = 0; tick = 0;
        model_step(r, f, t);
        n_short  += int'(short_press);
        n_long   += int'(long_press);
        n_double += int'(double_press);
    endtask

    task automatic step(input bit r, input bit f, input bit t);
        apply(r, f, t);
        check("model", int'(dut_out()), int'(m_out));
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // n tick periods of 4 clk each, the tick on the last clk.
    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            quiet(3);
            step(0, 0, 1);
        end
    endtask

    task automatic do_reset();
        press_redge = 0; press_fedge = 0; tick = 0;
        #2 rst_n = 0;
        #1 check("reset_outputs", int'(dut_out()), 0);
        @(negedge clk) rst_n = 1;
        model_reset();
        step(0, 0, 0);
        n_short = 0; n_long = 0; n_double = 0;
    endtask

    task automatic check_counts(input string name, input int s, input int l, input int d);
        check({name, "_short_cnt"}, n_short, s);
        check({name, "_long_cnt"}, n_long, l);
        check({name, "_double_cnt"}, n_double, d);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 5'b00011};  // redge -> PRESS1
        tbl[1]  = '{0, 0, 1, 5'b00011};
        tbl[2]  = '{0, 0, 1, 5'b00011};
        tbl[3]  = '{1, 1, 1, 5'b00011};  // both edges + tick ignored
        tbl[4]  = '{0, 1, 1, 5'b00001};  // fedge beats tick -> WAIT2
        tbl[5]  = '{0, 0, 1, 5'b00001};
        tbl[6]  = '{0, 0, 1, 5'b00001};
        tbl[7]  = '{0, 1, 0, 5'b00001};  // redundant fedge
        tbl[8]  = '{0, 0, 1, 5'b00001};
        tbl[9]  = '{0, 0, 1, 5'b10000};  // 4th tick -> short_press
        tbl[10] = '{0, 0, 0, 5'b00000};
        tbl[11] = '{0, 1, 0, 5'b00000};  // fedge in IDLE
        tbl[12] = '{1, 1, 0, 5'b00000};  // coincident edges in IDLE

        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset_state", int'(dut_out()), 0);
        do_reset();

        // Table vectors
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].r, tbl[i].f, tbl[i].t);
            check($sformatf("vec%0d", i), int'(dut_out()), int'(tbl[i].exp));
        end

        // Reset mid-PRESS1, then a fresh short press
        do_reset();
        step(1, 0, 0);
        idle_ticks(3);
        check("pre_reset_held", int'(held), 1);
        do_reset();
        step(0, 1, 0);
        check("post_reset_idle", int'(dut_out()), 0);
        step(1, 0, 0);
        idle_ticks(2);
        step(0, 1, 0);
        idle_ticks(4);
        quiet(8);
        check_counts("after_reset", 1, 0, 0);

        // Short press: pulse one clk after the 4th tick after release
        do_reset();
        step(1, 0, 0);
        idle_ticks(2);
        step(0, 1, 0);
        idle_ticks(3);
        check("short_early", int'(short_press), 0);
        quiet(3);
        step(0, 0, 1);
        check("short_pulse", int'(dut_out()), 5'b10000);
        step(0, 0, 0);
        check("short_one_clk", int'(short_press), 0);
        idle_ticks(6);
        check_counts("short", 1, 0, 0);

        // Long press
        do_reset();
        step(1, 0, 0);
        idle_ticks(7);
        check("long_early", int'(long_press), 0);
        quiet(3);
        step(0, 0, 1);
        check("long_pulse", int'(dut_out()), 5'b01011);
        idle_ticks(2);
        check("long_still_held", int'(dut_out()), 5'b00011);
        step(0, 1, 0);
        check("long_release", int'(dut_out()), 0);
        idle_ticks(6);
        check_counts("long", 0, 1, 0);

        // Double press
        do_reset();
        step(1, 0, 0);
        idle_ticks(1);
        step(0, 1, 0);
        idle_ticks(2);
        step(1, 0, 0);
        idle_ticks(1);
        step(0, 1, 0);
        check("double_pulse", int'(dut_out()), 5'b00100);
        idle_ticks(6);
        check_counts("double", 0, 0, 1);

        // Second press held long
        do_reset();
        step(1, 0, 0);
        idle_ticks(1);
        step(0, 1, 0);
        idle_ticks(1);
        step(1, 0, 0);
        idle_ticks(7);
        quiet(3);
        step(0, 0, 1);
        check("second_long_pulse", int'(dut_out()), 5'b01011);
        step(0, 1, 0);
        idle_ticks(6);
        check_counts("second_long", 0, 1, 0);

        // Coincident edges in IDLE, tick coinciding with release
        do_reset();
        step(1, 1, 0);
        check("both_edges_idle", int'(busy), 0);
        step(1, 0, 0);
        idle_ticks(1);
        quiet(3);
        step(0, 1, 1);
        check("fedge_tick", int'(dut_out()), 5'b00001);
        idle_ticks(3);
        check("window_not_short", int'(short_press), 0);
        quiet(3);
        step(0, 0, 1);
        check("window_full", int'(short_press), 1);

        // Randomized against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 (i % 4 == 3) || ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
